link_supervisor: RTL and testbench

Bring-up and recovery controller for the HDMI pass-through link. It runs on the 200 MHz reference clock. It watches the deserializer MMCM lock, IDELAYCTRL ready and the per-channel `vld_cb` flags from the three TMDS receivers. From these it sequences receiver reset, qualifies channel alignment, and gates the CDC FIFO and TX path, retrying with a bounded count before declaring failure.

---
 rtl/link_supervisor.sv | 140 ++++++++++++++
 tb/tb_link_supervisor.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/link_supervisor.sv
// HDMI receive link bring-up / recovery sequencer.
// Sequences receiver reset, qualifies TMDS channel alignment, and gates the FIFO and TX path with a bounded retry count.
module link_supervisor #(
    parameter int unsigned LOCK_SETTLE   = 2048,
    parameter int unsigned RST_CYCLES    = 64,
    parameter int unsigned VALID_TIMEOUT = 10000000,
    parameter int unsigned STABLE_CYCLES = 200000,
    parameter int unsigned LOSS_FILTER   = 16,
    parameter int unsigned MAX_RETRY     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       locked_des,
    input  logic       ideready,
    input  logic [2:0] vld_cb,
    output logic       rx_rst,
    output logic       fifo_flush,
    output logic       tx_en,
    output logic       link_up,
    output logic       fail,
    output logic [2:0] state,
    output logic [3:0] retry_cnt
);

    typedef enum logic [2:0] {
        S_WAIT_CLK = 3'd0,
        S_RX_RST   = 3'd1,
        S_ALIGN    = 3'd2,
        S_QUALIFY  = 3'd3,
        S_UP       = 3'd4,
        S_FAIL     = 3'd5
    } state_t;

    localparam logic [23:0] C_LOCK   = 24'(LOCK_SETTLE - 1);
    localparam logic [23:0] C_RST    = 24'(RST_CYCLES - 1);
    localparam logic [23:0] C_VALID  = 24'(VALID_TIMEOUT - 1);
    localparam logic [23:0] C_STABLE = 24'(STABLE_CYCLES - 1);
    localparam logic [23:0] C_LOSS   = 24'(LOSS_FILTER - 1);
    localparam logic [3:0]  C_MAXR   = 4'(MAX_RETRY);

    state_t      r_state;
    logic [23:0] r_tmr;
    logic [3:0]  r_retry;

    logic        w_clk_ok;
    logic        w_all_vld;
    logic [3:0]  w_retry_inc;
    state_t      w_retry_dst;

    assign w_clk_ok    = locked_des & ideready;
    assign w_all_vld   = &vld_cb;
    assign w_retry_inc = (r_retry == 4'd15) ? 4'd15 : r_retry + 4'd1;
    assign w_retry_dst = (w_retry_inc >= C_MAXR) ? S_FAIL : S_RX_RST;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_WAIT_CLK;
            r_tmr   <= '0;
            r_retry <= '0;
        end else if (!w_clk_ok && r_state != S_WAIT_CLK) begin
            // clock loss restarts bring-up but keeps the retry history
            r_state <= S_WAIT_CLK;
            r_tmr   <= '0;
        end else begin
            case (r_state)
                S_WAIT_CLK: begin
                    if (!w_clk_ok) begin
                        r_tmr <= '0;
                    end else if (r_tmr == C_LOCK) begin
                        r_state <= S_RX_RST;
                        r_tmr   <= '0;
                    end else begin
                        r_tmr <= r_tmr + 24'd1;
                    end
                end
                S_RX_RST: begin
                    if (r_tmr == C_RST) begin
                        r_state <= S_ALIGN;
                        r_tmr   <= '0;
                    end else begin
                        r_tmr <= r_tmr + 24'd1;
                    end
                end
                S_ALIGN: begin
                    if (w_all_vld) begin
                        r_state <= S_QUALIFY;
                        r_tmr   <= '0;
                    end else if (r_tmr == C_VALID) begin
                        r_state <= w_retry_dst;
                        r_retry <= w_retry_inc;
                        r_tmr   <= '0;
                    end else begin
                        r_tmr <= r_tmr + 24'd1;
                    end
                end
                S_QUALIFY: begin
                    if (!w_all_vld) begin
                        r_state <= w_retry_dst;
                        r_retry <= w_retry_inc;
                        r_tmr   <= '0;
                    end else if (r_tmr == C_STABLE) begin
                        r_state <= S_UP;
                        r_retry <= '0;
                        r_tmr   <= '0;
                    end else begin
                        r_tmr <= r_tmr + 24'd1;
                    end
                end
                S_UP: begin
                    // timer here counts consecutive invalid samples only
                    if (w_all_vld) begin
                        r_tmr <= '0;
                    end else if (r_tmr == C_LOSS) begin
                        r_state <= w_retry_dst;
                        r_retry <= w_retry_inc;
                        r_tmr   <= '0;
                    end else begin
                        r_tmr <= r_tmr + 24'd1;
                    end
                end
                S_FAIL: begin
                    r_state <= S_FAIL;
                end
                default: begin
                    r_state <= S_WAIT_CLK;
                    r_tmr   <= '0;
                end
            endcase
        end
    end

    assign rx_rst     = (r_state == S_WAIT_CLK) || (r_state == S_RX_RST) || (r_state == S_FAIL);
    assign fifo_flush = (r_state != S_UP);
    assign tx_en      = (r_state == S_UP);
    assign link_up    = (r_state == S_UP);
    assign fail       = (r_state == S_FAIL);
    assign state      = r_state;
    assign retry_cnt  = r_retry;

endmodule

// File: tb/tb_link_supervisor.sv
// Bench for link_supervisor: directed vector table plus randomized run against a sample-counting reference model.
module tb_link_supervisor;

    localparam int LS = 8, RC = 4, VT = 16, SC = 8, LF = 3, MR = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       lk = 1'b1;
    logic       ide = 1'b1;
    logic [2:0] vld = 3'b111;
    logic       rx_rst, fifo_flush, tx_en, link_up, fail;
    logic [2:0] state;
    logic [3:0] retry_cnt;

    int n_checks = 0;
    int n_pass = 0;

    // reference model: phase plus number of qualifying samples seen in it
    int m_ph = 0;
    int m_seen = 0;
    int m_retry = 0;

    always #5 clk = ~clk;

    link_supervisor #(
        .LOCK_SETTLE(LS), .RST_CYCLES(RC), .VALID_TIMEOUT(VT),
        .STABLE_CYCLES(SC), .LOSS_FILTER(LF), .MAX_RETRY(MR)
    ) dut (
        .clk(clk), .rst(rst), .locked_des(lk), .ideready(ide), .vld_cb(vld),
        .rx_rst(rx_rst), .fifo_flush(fifo_flush), .tx_en(tx_en),
        .link_up(link_up), .fail(fail), .state(state), .retry_cnt(retry_cnt)
    );

    typedef struct {
        int         n;
        logic       rst;
        logic       lk;
        logic       ide;
        logic [2:0] vld;
        logic [2:0] st;
        logic [3:0] rc;
    } vec_t;

    vec_t tbl[$];

    // {rx_rst, fifo_flush, tx_en, link_up, fail} required for a given state
    function automatic logic [4:0] outs_for(input int s);
        return {(s == 0 || s == 1 || s == 5), (s != 4), (s == 4), (s == 4), (s == 5)};
    endfunction

    task automatic do_retry();
        m_retry = (m_retry >= 15) ? 15 : m_retry + 1;
        m_ph    = (m_retry >= MR) ? 5 : 1;
        m_seen  = 0;
    endtask

    task automatic model_step();
        if (rst) begin
            m_ph = 0; m_seen = 0; m_retry = 0;
        end else if (!(lk && ide)) begin
            m_ph = 0; m_seen = 0;
        end else begin
            case (m_ph)
                0: begin m_seen++; if (m_seen == LS) begin m_ph = 1; m_seen = 0; end end
                1: begin m_seen++; if (m_seen == RC) begin m_ph = 2; m_seen = 0; end end
                2: if (vld == 3'b111) begin m_ph = 3; m_seen = 0; end
                   else begin m_seen++; if (m_seen == VT) do_retry(); end
                3: if (vld != 3'b111) do_retry();
                   else begin
                       m_seen++;
                       if (m_seen == SC) begin m_ph = 4; m_seen = 0; m_retry = 0; end
                   end
                4: if (vld == 3'b111) m_seen = 0;
                   else begin m_seen++; if (m_seen == LF) do_retry(); end
                default: ;
            endcase
        end
    endtask

    task automatic tick();
        logic [11:0] got, exp;
        @(posedge clk);
        model_step();
        #1;
        got = {state, retry_cnt, rx_rst, fifo_flush, tx_en, link_up, fail};
        exp = {3'(m_ph), 4'(m_retry), outs_for(m_ph)};
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL model t=%0t got=%h required=%h", $time, got, exp);
    endtask

    task automatic add(input int n, input logic r, input logic l, input logic i,
                       input logic [2:0] v, input logic [2:0] s, input logic [3:0] c);
        vec_t e;
        e.n = n; e.rst = r; e.lk = l; e.ide = i; e.vld = v; e.st = s; e.rc = c;
        tbl.push_back(e);
    endtask

    initial begin
        logic [11:0] got, exp;
        int vprob;

        // clean bring-up
        add(1, 1, 1, 1, 3'b111, 0, 0);
        add(7, 0, 1, 1, 3'b111, 0, 0);
        add(1, 0, 1, 1, 3'b111, 1, 0);
        add(3, 0, 1, 1, 3'b111, 1, 0);
        add(1, 0, 1, 1, 3'b111, 2, 0);
        add(1, 0, 1, 1, 3'b111, 3, 0);
        add(7, 0, 1, 1, 3'b111, 3, 0);
        add(1, 0, 1, 1, 3'b111, 4, 0);
        // lock drop in UP, then 1-cycle glitch at WAIT_CLK tmr=5
        add(1, 0, 0, 1, 3'b111, 0, 0);
        add(5, 0, 1, 1, 3'b111, 0, 0);
        add(1, 0, 0, 1, 3'b111, 0, 0);
        add(7, 0, 1, 1, 3'b111, 0, 0);
        add(1, 0, 1, 1, 3'b111, 1, 0);
        add(4, 0, 1, 1, 3'b111, 2, 0);
        add(1, 0, 1, 1, 3'b111, 3, 0);
        add(7, 0, 1, 1, 3'b111, 3, 0);
        add(1, 0, 1, 1, 3'b111, 4, 0);
        // loss filter: 2 low samples tolerated, 3rd retries
        add(2, 0, 1, 1, 3'b110, 4, 0);
        add(1, 0, 1, 1, 3'b111, 4, 0);
        add(2, 0, 1, 1, 3'b110, 4, 0);
        add(1, 0, 1, 1, 3'b110, 1, 1);
        // sync reset mid-QUALIFY
        add(4, 0, 1, 1, 3'b111, 2, 1);
        add(3, 0, 1, 1, 3'b111, 3, 1);
        add(1, 1, 1, 1, 3'b111, 0, 0);
        // qualify dropout at tmr=4, then clean pass clears retry
        add(8, 0, 1, 1, 3'b111, 1, 0);
        add(4, 0, 1, 1, 3'b111, 2, 0);
        add(5, 0, 1, 1, 3'b111, 3, 0);
        add(1, 0, 1, 1, 3'b101, 1, 1);
        add(4, 0, 1, 1, 3'b111, 2, 1);
        add(8, 0, 1, 1, 3'b111, 3, 1);
        add(1, 0, 1, 1, 3'b111, 4, 0);
        // align timeouts to FAIL
        add(1, 1, 1, 1, 3'b011, 0, 0);
        add(8, 0, 1, 1, 3'b011, 1, 0);
        add(4, 0, 1, 1, 3'b011, 2, 0);
        add(15, 0, 1, 1, 3'b011, 2, 0);
        add(1, 0, 1, 1, 3'b011, 1, 1);
        add(4, 0, 1, 1, 3'b011, 2, 1);
        add(15, 0, 1, 1, 3'b011, 2, 1);
        add(1, 0, 1, 1, 3'b011, 1, 2);
        add(4, 0, 1, 1, 3'b011, 2, 2);
        add(15, 0, 1, 1, 3'b011, 2, 2);
        add(1, 0, 1, 1, 3'b011, 5, 3);
        add(20, 0, 1, 1, 3'b111, 5, 3);
        add(1, 0, 1, 0, 3'b111, 0, 3);

        foreach (tbl[k]) begin
            rst = tbl[k].rst; lk = tbl[k].lk; ide = tbl[k].ide; vld = tbl[k].vld;
            repeat (tbl[k].n) tick();
            got = {state, retry_cnt, rx_rst, fifo_flush, tx_en, link_up, fail};
            exp = {tbl[k].st, tbl[k].rc, outs_for(int'(tbl[k].st))};
            n_checks++;
            if (got === exp) n_pass++;
            else $display("FAIL vec%0d {state,retry,outs} got=%h required=%h", k, got, exp);
        end

        // randomized run; valid quality varies per block so every state is visited
        rst = 1'b1; lk = 1'b1; ide = 1'b1; vld = 3'b111;
        tick();
        vprob = 100;
        for (int c = 0; c < 4000; c++) begin
            if (c % 64 == 0) begin
                case ($urandom_range(0, 3))
                    0: vprob = 100;
                    1: vprob = 97;
                    2: vprob = 85;
                    default: vprob = 40;
                endcase
            end
            rst = ($urandom_range(0, 599) == 0);
            lk  = ($urandom_range(0, 249) != 0);
            ide = ($urandom_range(0, 499) != 0);
            vld = ($urandom_range(0, 99) < vprob) ? 3'b111 : 3'($urandom);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
